// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: checks that a sampled counter steps by +1 mod 2**WIDTH.
// It locks after LOCK_CNT good steps, then flags and counts every sequence break.
module cnt_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 16,
    parameter int HOLD_OK  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_valid,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last_val
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    state_t        state;
    logic [GW-1:0] good;
    logic          match, hold, brk;
    assign match  = cnt_in == last_val + WIDTH'(1);
    assign hold   = HOLD_OK != 0 && cnt_in == last_val;
    assign brk    = cnt_valid && state == LOCKED && !match && !hold;
    assign locked = state == LOCKED;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            good      <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            last_val  <= '0;
        end else begin
            err_pulse <= brk;
            // a clear in the same cycle as a break wins over the increment
            err_count <= clr_err ? '0 : (brk && !(&err_count)) ? err_count + 1'b1 : err_count;
            if (cnt_valid) begin
                last_val <= cnt_in;
                case (state)
                    IDLE: begin
                        good  <= '0;
                        state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (match) begin
                            if (good == GW'(LOCK_CNT - 1)) begin
                                good  <= '0;
                                state <= LOCKED;
                            end else begin
                                good <= good + 1'b1;
                            end
                        end else if (!hold) begin
                            good <= '0;
                        end
                    end
                    LOCKED: begin
                        if (brk) begin
                            good  <= '0;
                            state <= ACQUIRE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb_cnt_seq_checker: directed checks of three checker variants driven by one shared stream.
// a = defaults, h = HOLD_OK=1, e = ERR_W=2.
module tb_cnt_seq_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cnt_valid = 1'b0;
    logic [7:0] cnt_in = '0;
    logic       clr_err = 1'b0;
    logic       a_locked, a_pulse, h_locked, h_pulse, e_locked, e_pulse;
    logic [15:0] a_err, h_err;
    logic [1:0]  e_err;
    logic [7:0]  a_last, h_last, e_last;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cnt_seq_checker u_a (
        .clk(clk), .rst(rst), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(a_locked), .err_pulse(a_pulse), .err_count(a_err), .last_val(a_last)
    );
    cnt_seq_checker #(.HOLD_OK(1)) u_h (
        .clk(clk), .rst(rst), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(h_locked), .err_pulse(h_pulse), .err_count(h_err), .last_val(h_last)
    );
    cnt_seq_checker #(.ERR_W(2)) u_e (
        .clk(clk), .rst(rst), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(e_locked), .err_pulse(e_pulse), .err_count(e_err), .last_val(e_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        cnt_valid = 1'b1;
        cnt_in    = v;
        tick();
        cnt_valid = 1'b0;
    endtask

    task automatic relock(input logic [7:0] v);
        for (int k = 1; k <= 4; k++) send(v + 8'(k));
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_locked", a_locked, 0);
        chk("rst_err", a_err, 0);
        chk("rst_last", a_last, 0);
        chk("rst_pulse", a_pulse, 0);
        // lock on 10..14
        for (int v = 8'h10; v <= 8'h13; v++) send(8'(v));
        chk("t1_not_yet", a_locked, 0);
        send(8'h14);
        chk("t1_locked", a_locked, 1);
        chk("t1_err", a_err, 0);
        chk("t1_last", a_last, 8'h14);
        tick();
        chk("idle_cycle_locked", a_locked, 1);
        chk("idle_cycle_pulse", a_pulse, 0);
        // break at 20 -> 25, relock on 26..29
        for (int v = 8'h15; v <= 8'h20; v++) send(8'(v));
        chk("t3_pre_last", a_last, 8'h20);
        send(8'h25);
        chk("t3_pulse", a_pulse, 1);
        chk("t3_err", a_err, 1);
        chk("t3_locked", a_locked, 0);
        tick();
        chk("t3_pulse_one_cycle", a_pulse, 0);
        send(8'h26);
        send(8'h27);
        send(8'h28);
        chk("t3_acq", a_locked, 0);
        chk("t3_acq_pulse", a_pulse, 0);
        send(8'h29);
        chk("t3_relock", a_locked, 1);
        chk("t3_err_kept", a_err, 1);
        // wrap: break to F9, lock at FD, then FE,FF,00,01
        send(8'hF9);
        chk("t2_break_err", a_err, 2);
        relock(8'hF9);
        chk("t2_locked", a_locked, 1);
        send(8'hFE);
        send(8'hFF);
        chk("t2_ff_pulse", a_pulse, 0);
        send(8'h00);
        chk("t2_wrap_pulse", a_pulse, 0);
        chk("t2_wrap_locked", a_locked, 1);
        send(8'h01);
        chk("t2_last", a_last, 8'h01);
        chk("t2_err", a_err, 2);
        // hold handling: lock at 30, then 30 again, then 31
        send(8'h2C);
        relock(8'h2C);
        chk("t4_locked", h_locked, 1);
        chk("t4_err_h", h_err, 3);
        send(8'h30);
        chk("t4_hold_h_pulse", h_pulse, 0);
        chk("t4_hold_h_locked", h_locked, 1);
        chk("t4_hold_a_pulse", a_pulse, 1);
        chk("t4_hold_a_err", a_err, 4);
        chk("t4_hold_a_locked", a_locked, 0);
        chk("t4_hold_e_sat", e_err, 3);
        send(8'h31);
        chk("t4_h_after", h_err, 3);
        chk("t4_h_last", h_last, 8'h31);
        // clear, relock, then five forced breaks on the 2-bit counter
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_a", a_err, 0);
        chk("clr_e", e_err, 0);
        send(8'h32);
        send(8'h33);
        send(8'h34);
        chk("t5_locked", e_locked, 1);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'h50 + 8'(i * 16);
            send(b);
            chk("t5_e_pulse", e_pulse, 1);
            chk("t5_e_err", e_err, (i + 1 > 3) ? 3 : i + 1);
            chk("t5_a_err", a_err, i + 1);
            relock(b);
        end
        chk("t5_relocked", e_locked, 1);
        clr_err = 1'b1;
        send(8'hC0);
        clr_err = 1'b0;
        chk("t5_clr_break_err", e_err, 0);
        chk("t5_clr_break_pulse", e_pulse, 1);
        chk("t5_clr_break_a", a_err, 0);
        // reach err_count=2 while locked, then reset
        relock(8'hC0);
        send(8'hD0);
        relock(8'hD0);
        send(8'hE0);
        relock(8'hE0);
        chk("t6_pre_locked", a_locked, 1);
        chk("t6_pre_err", a_err, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_locked", a_locked, 0);
        chk("t6_err", a_err, 0);
        chk("t6_last", a_last, 0);
        send(8'h55);
        chk("t6_idle_pulse", a_pulse, 0);
        chk("t6_idle_last", a_last, 8'h55);
        send(8'h77);
        chk("t6_acq_pulse", a_pulse, 0);
        chk("t6_acq_err", a_err, 0);
        chk("t6_acq_locked", a_locked, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
